// File: rtl/alarm_ring_ctl_if.sv
// Signal bundle between the clock/alarm-set stages, the ring controller and the buzzer.
// The master side drives the time and buttons. The slave side is the controller, which drives the ring status.
interface alarm_ring_ctl_if;
   logic [31:0] time_in;
   logic [31:0] alarm_in;
   logic        alarm_en;
   logic        stop;
   logic        snooze;
   logic        alarm_ringing;
   logic        buzzer_en;
   logic        snoozing;
   logic [1:0]  snooze_cnt;

   modport master (
      output time_in, alarm_in, alarm_en, stop, snooze,
      input  alarm_ringing, buzzer_en, snoozing, snooze_cnt
   );

   modport slave (
      input  time_in, alarm_in, alarm_en, stop, snooze,
      output alarm_ringing, buzzer_en, snoozing, snooze_cnt
   );
endinterface

// File: rtl/alarm_ring_ctl.sv
// Alarm trigger / ring controller.
// An alarm event starts on the rising edge of an HH:MM match while the alarm is armed.
// Each event runs a ringing session with auto-timeout, stop, and a limited number of snoozes.
// While ringing, a square-wave beep enable is produced for the buzzer.
module alarm_ring_ctl #(
   parameter int TICKS_PER_SEC = 1000,
   parameter int RING_SEC      = 60,
   parameter int SNOOZE_SEC    = 300,
   parameter int SNOOZE_MAX    = 3,
   parameter int BEEP_MS       = 500
) (
   input  logic            clk_1khz,
   input  logic            rst_n,
   alarm_ring_ctl_if.slave bus
);

   localparam int RING_TICKS = RING_SEC * TICKS_PER_SEC;
   localparam int SNZ_TICKS  = SNOOZE_SEC * TICKS_PER_SEC;
   localparam int MAX_TICKS  = (RING_TICKS > SNZ_TICKS) ? RING_TICKS : SNZ_TICKS;
   localparam int CW         = $clog2(MAX_TICKS + 1);
   localparam int PHASES     = 2 * BEEP_MS;
   localparam int PW         = (PHASES > 1) ? $clog2(PHASES) : 1;

   localparam logic [CW-1:0] CNT_SAT   = CW'(MAX_TICKS);
   localparam logic [CW-1:0] RING_LAST = CW'(RING_TICKS - 1);
   localparam logic [CW-1:0] SNZ_LAST  = CW'(SNZ_TICKS - 1);
   localparam logic [PW-1:0] PH_LAST   = PW'(PHASES - 1);
   localparam logic [PW-1:0] PH_ON     = PW'(BEEP_MS);
   localparam logic [1:0]    SNZ_LIM   = 2'(SNOOZE_MAX);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RINGING = 2'd1,
      ST_SNOOZE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic          r_match_d;
   logic          r_stop_d;
   logic          r_snooze_d;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] r_phase;
   logic [1:0]    r_snz_cnt;

   logic [31:0]   w_diff;
   logic          w_match;
   logic          w_match_rise;
   logic          w_stop_rise;
   logic          w_snooze_rise;
   logic          w_clr;       // entering a fresh ringing or snooze interval
   logic          w_trig;      // new alarm event: snooze budget restarts
   logic          w_snz_inc;

   // Only the BCD low nibble of each digit takes part in the compare.
   // The upper nibbles are masked off, and no BCD range check is made.
   assign w_diff        = bus.time_in ^ bus.alarm_in;
   assign w_match       = ~|(w_diff & 32'h0F0F_0F0F);
   assign w_match_rise  = w_match & ~r_match_d;
   assign w_stop_rise   = bus.stop & ~r_stop_d;
   assign w_snooze_rise = bus.snooze & ~r_snooze_d;

   // Edge-detect history. It resets high, so a match or a button that is already high at reset does not act.
   always_ff @(posedge clk_1khz) begin
      if (!rst_n) begin
         r_match_d  <= 1'b1;
         r_stop_d   <= 1'b1;
         r_snooze_d <= 1'b1;
      end else begin
         r_match_d  <= w_match;
         r_stop_d   <= bus.stop;
         r_snooze_d <= bus.snooze;
      end
   end

   // Next-state decision. In RINGING, disarm beats stop, stop beats timeout, and timeout beats snooze.
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_trig      = 1'b0;
      w_snz_inc   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_match_rise && bus.alarm_en) begin
               w_state_nxt = ST_RINGING;
               w_clr       = 1'b1;
               w_trig      = 1'b1;
            end
         end
         ST_RINGING: begin
            if (!bus.alarm_en || w_stop_rise) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt >= RING_LAST) begin
               w_state_nxt = ST_IDLE;
            end else if (w_snooze_rise && (r_snz_cnt < SNZ_LIM)) begin
               w_state_nxt = ST_SNOOZE;
               w_clr       = 1'b1;
               w_snz_inc   = 1'b1;
            end
         end
         ST_SNOOZE: begin
            if (!bus.alarm_en || w_stop_rise) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt >= SNZ_LAST) begin
               w_state_nxt = ST_RINGING;
               w_clr       = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_1khz) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Interval counter. It restarts on every interval entry and saturates instead of wrapping.
   always_ff @(posedge clk_1khz) begin
      if (!rst_n)                                   r_cnt <= '0;
      else if (w_clr)                               r_cnt <= '0;
      else if (r_state != ST_IDLE && r_cnt != CNT_SAT) r_cnt <= r_cnt + 1'b1;
   end

   // Beep phase. It free-runs only while ringing, and every new ringing interval starts at the on-phase.
   always_ff @(posedge clk_1khz) begin
      if (!rst_n)                     r_phase <= '0;
      else if (w_clr)                 r_phase <= '0;
      else if (r_state == ST_RINGING) r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
   end

   // Snooze usage per alarm event. The value is kept after a stop until the next trigger.
   always_ff @(posedge clk_1khz) begin
      if (!rst_n)         r_snz_cnt <= 2'd0;
      else if (w_trig)    r_snz_cnt <= 2'd0;
      else if (w_snz_inc) r_snz_cnt <= r_snz_cnt + 2'd1;
   end

   assign bus.alarm_ringing = (r_state == ST_RINGING);
   assign bus.buzzer_en     = (r_state == ST_RINGING) && (r_phase < PH_ON);
   assign bus.snoozing      = (r_state == ST_SNOOZE);
   assign bus.snooze_cnt    = r_snz_cnt;

endmodule

// File: tb/tb_alarm_ring_ctl.sv
// Directed bench for alarm_ring_ctl, using scaled-down timing (10 ticks/s, 3 s ring, 2 s snooze, 2-tick beep).
// Expected outputs are queued when stimulus is applied and popped for comparison after the clock edge.
module tb_alarm_ring_ctl;

   logic clk_1khz = 1'b0;
   logic rst_n;

   alarm_ring_ctl_if ifc ();

   alarm_ring_ctl #(
      .TICKS_PER_SEC(10),
      .RING_SEC     (3),
      .SNOOZE_SEC   (2),
      .SNOOZE_MAX   (3),
      .BEEP_MS      (2)
   ) dut (
      .clk_1khz(clk_1khz),
      .rst_n   (rst_n),
      .bus     (ifc)
   );

   always #5 clk_1khz = ~clk_1khz;

   typedef struct {
      string      tag;
      logic [4:0] v;   // {ringing, buzzer, snoozing, snooze_cnt}
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   localparam logic [31:0] T0729 = 32'h0007_0209;
   localparam logic [31:0] T0730 = 32'h0007_0300;

   // Queue an expectation, advance one edge, then compare once the outputs have settled.
   task automatic tick_chk(input string tag, input bit r, input bit b, input bit s, input logic [1:0] c);
      exp_t       e;
      logic [4:0] obs;
      sb.push_back('{tag, {r, b, s, c}});
      @(posedge clk_1khz);
      #1;
      obs = {ifc.alarm_ringing, ifc.buzzer_en, ifc.snoozing, ifc.snooze_cnt};
      e   = sb.pop_front();
      total++;
      assert (obs === e.v) else begin
         bad++;
         $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
      end
   endtask

   task automatic tick();
      @(posedge clk_1khz);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      ifc.time_in  = 32'h0;
      ifc.alarm_in = 32'h0;
      ifc.alarm_en = 1'b1;
      ifc.stop     = 1'b0;
      ifc.snooze   = 1'b0;
      tick();
      tick();
      tick_chk("reset", 0, 0, 0, 2'd0);

      // A time that already matches at reset release must not ring.
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick_chk("no_ring_at_reset", 0, 0, 0, 2'd0);

      // Basic trigger, beep pattern 1,1,0,0, and auto-stop after 30 cycles.
      ifc.alarm_in = T0730;
      ifc.time_in  = T0729;
      tick_chk("pre_match", 0, 0, 0, 2'd0);
      ifc.time_in = T0730;
      for (int i = 0; i < 30; i++) tick_chk("ring_beep", 1, (i % 4) < 2, 0, 2'd0);
      tick_chk("timeout", 0, 0, 0, 2'd0);

      // Stop ends ringing on the next edge, and a held match does not retrigger.
      ifc.time_in = T0729;
      tick();
      ifc.time_in = T0730;
      for (int i = 0; i < 5; i++) tick_chk("ring2", 1, (i % 4) < 2, 0, 2'd0);
      ifc.stop = 1'b1;
      tick_chk("stop", 0, 0, 0, 2'd0);
      ifc.stop = 1'b0;
      for (int i = 0; i < 100; i++) tick_chk("no_retrigger", 0, 0, 0, 2'd0);

      // Three snoozes, each re-ringing after 20 cycles. A fourth snooze is ignored.
      ifc.time_in = T0729;
      tick();
      ifc.time_in = T0730;
      for (int i = 0; i < 3; i++) tick_chk("ring3", 1, (i % 4) < 2, 0, 2'd0);
      for (int n = 1; n <= 3; n++) begin
         ifc.snooze = 1'b1;
         for (int k = 0; k < 20; k++) begin
            tick_chk("snoozing", 0, 0, 1, 2'(n));
            ifc.snooze = 1'b0;
         end
         for (int i = 0; i < 3; i++) tick_chk("rering", 1, (i % 4) < 2, 0, 2'(n));
      end
      ifc.snooze = 1'b1;
      tick_chk("snooze_ignored", 1, 0, 0, 2'd3);
      ifc.snooze = 1'b0;
      tick_chk("still_ringing", 1, 1, 0, 2'd3);
      ifc.stop = 1'b1;
      tick_chk("stop_keeps_cnt", 0, 0, 0, 2'd3);
      ifc.stop = 1'b0;
      tick_chk("idle_keeps_cnt", 0, 0, 0, 2'd3);

      // A new trigger clears the count. Simultaneous stop and snooze: stop wins.
      ifc.time_in = T0729;
      tick();
      ifc.time_in = T0730;
      tick_chk("retrigger_clr", 1, 1, 0, 2'd0);
      tick_chk("ring5", 1, 1, 0, 2'd0);
      ifc.stop   = 1'b1;
      ifc.snooze = 1'b1;
      tick_chk("stop_wins", 0, 0, 0, 2'd0);
      ifc.stop   = 1'b0;
      ifc.snooze = 1'b0;
      tick_chk("stop_wins_idle", 0, 0, 0, 2'd0);

      // A disarmed alarm ignores the match, and arming while already matching does not ring.
      ifc.time_in  = T0729;
      ifc.alarm_en = 1'b0;
      tick();
      ifc.time_in = T0730;
      for (int i = 0; i < 3; i++) tick_chk("disarmed", 0, 0, 0, 2'd0);
      ifc.alarm_en = 1'b1;
      for (int i = 0; i < 3; i++) tick_chk("arm_late", 0, 0, 0, 2'd0);

      // Disarming while ringing returns to idle.
      ifc.time_in = T0729;
      tick();
      ifc.time_in = T0730;
      tick_chk("ring6", 1, 1, 0, 2'd0);
      ifc.alarm_en = 1'b0;
      tick_chk("disarm_ringing", 0, 0, 0, 2'd0);
      ifc.alarm_en = 1'b1;

      // Reset during snooze clears everything.
      ifc.time_in = T0729;
      tick();
      ifc.time_in = T0730;
      tick_chk("ring7", 1, 1, 0, 2'd0);
      ifc.snooze = 1'b1;
      tick_chk("snooze7", 0, 0, 1, 2'd1);
      ifc.snooze = 1'b0;
      tick_chk("snooze7b", 0, 0, 1, 2'd1);
      rst_n = 1'b0;
      tick_chk("reset_in_snooze", 0, 0, 0, 2'd0);
      rst_n = 1'b1;
      tick_chk("post_reset_idle", 0, 0, 0, 2'd0);

      // Different upper nibbles with equal low nibbles still count as a match.
      ifc.time_in = T0729;
      tick();
      ifc.time_in = 32'hA0F7_5360;
      tick_chk("upper_nibble_trig", 1, 1, 0, 2'd0);
      tick_chk("upper_nibble_ring", 1, 1, 0, 2'd0);

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
